// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder sequencer:
//   state_e : controller state encoding (IDLE, SHIFT, DONE)
//   cnt_w() : bit-counter width for a given operand width (minimum 1 bit)
// -----------------------------------------------------------------------------
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // $clog2 returns 0 for widths 1..1, so clamp to a single counter bit.
  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa1.sv
// -----------------------------------------------------------------------------
// fa1
// Combinational 1-bit full adder cell.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit   (a ^ b ^ ci)
//   co   : carry out (majority of a, b, ci)
// -----------------------------------------------------------------------------
module fa1 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder: feeds two WIDTH-bit operands LSB-first through a single
// fa1 cell, one bit per clock, and reports the assembled sum with a done pulse.
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin an addition (only looked at in IDLE)
//   a_in     : operand A, captured on the accepting edge
//   b_in     : operand B, captured on the accepting edge
//   ci_in    : carry in, captured on the accepting edge
//   busy     : high while not IDLE
//   done     : one-cycle pulse when sum_out/co_out become valid
//   sum_out  : result, held until the next completion
//   co_out   : carry out of the MSB, held with sum_out
// -----------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             ci_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             co_out
);

  localparam int             CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_out_q, sum_out_d;
  logic             co_out_q, co_out_d;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] sum_next;

  fa1 u_fa1 (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_sum),
    .co (fa_carry)
  );

  // Right shift with the new sum bit entering at the MSB; written with shifts
  // so it stays legal for WIDTH=1.
  assign sum_next = (sum_sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    carry_d   = carry_q;
    sum_out_d = sum_out_q;
    co_out_d  = co_out_q;
    done_d    = 1'b0;
    busy_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a_in;
          b_sh_d   = b_in;
          carry_d  = ci_in;
          sum_sh_d = '0;
          cnt_d    = '0;
          state_d  = SHIFT;
          busy_d   = 1'b1;
        end else begin
          busy_d   = 1'b0;
        end
      end
      SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_next;
        carry_d  = fa_carry;
        busy_d   = 1'b1;
        if (cnt_q == LAST_CNT) begin
          // Final bit: publish the result on this same edge.
          cnt_d     = '0;
          state_d   = DONE;
          done_d    = 1'b1;
          sum_out_d = sum_next;
          co_out_d  = fa_carry;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // start is ignored here; the next request is seen back in IDLE.
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset discards any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      carry_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_out_q <= '0;
      co_out_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      carry_q   <= carry_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sum_out_q <= sum_out_d;
      co_out_q  <= co_out_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum_out = sum_out_q;
  assign co_out  = co_out_q;

endmodule
